// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N:1 operand selector feeding a 2-entry skid buffer.
// The selected beat is registered. The valid/ready interface runs at full
// throughput, and in_ready comes straight from a flop.
module mux_n_pipe #(
    parameter int WIDTH = 64,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] d,
    input  logic [SELW-1:0]    sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_err,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         count
);

    // Occupancy state; the bits mirror (main_valid, skid_valid).
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t             state_q,     state_d;
    logic [WIDTH-1:0]   main_data_q, main_data_d;
    logic               main_err_q,  main_err_d;
    logic [WIDTH-1:0]   skid_data_q, skid_data_d;
    logic               skid_err_q,  skid_err_d;
    logic [1:0]         count_q,     count_d;
    logic               in_ready_q,  in_ready_d;

    logic [WIDTH-1:0]   cap_data;
    logic               cap_err;
    logic               acc;
    logic               pop;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_data_q;
    assign out_err   = main_err_q;
    assign in_ready  = in_ready_q;
    assign count     = count_q;

    assign acc = in_valid & in_ready_q;
    assign pop = out_valid & out_ready;

    // Select the addressed input. Codes beyond N-1 give zero data and flag an error.
    always_comb begin
        cap_data = '0;
        cap_err  = 1'b1;
        for (int unsigned i = 0; i < N; i++) begin
            if (sel == SELW'(i)) begin
                cap_data = d[i*WIDTH +: WIDTH];
                cap_err  = 1'b0;
            end
        end
    end

    // Next-state, data movement and the registered occupancy/ready values.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_err_d  = main_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;
        case (state_q)
            EMPTY: begin
                if (acc) begin
                    state_d     = ONE;
                    main_data_d = cap_data;
                    main_err_d  = cap_err;
                end
            end
            ONE: begin
                if (acc && pop) begin
                    main_data_d = cap_data;
                    main_err_d  = cap_err;
                end else if (acc) begin
                    state_d     = FULL;
                    skid_data_d = cap_data;
                    skid_err_d  = cap_err;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d     = ONE;
                    main_data_d = skid_data_q;
                    main_err_d  = skid_err_q;
                end
            end
            default: state_d = EMPTY;
        endcase

        // count and in_ready are registered copies decoded from the next state.
        // This keeps out_ready off any combinational path to in_ready.
        case (state_d)
            ONE:     count_d = 2'd1;
            FULL:    count_d = 2'd2;
            default: count_d = 2'd0;
        endcase
        in_ready_d = (state_d != FULL);
    end

    // State and data registers; reset empties the buffer and clears the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
            count_q     <= 2'd0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_err_q  <= main_err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
        end
    end

endmodule

// File: doc/mux_n_pipe.md
Name: mux_n_pipe

Overview:
Parametrised N:1 datapath selector with a registered, flow-controlled output. It is the successor to the combinational 2:1 mux used throughout the core. It is used where the selected operand must be pipelined across a stage boundary, such as the writeback-source select or the forwarding select into EX. Each accepted beat captures one selected input into a 2-entry skid buffer, giving a full-throughput valid/ready interface with registered in_ready.

Parameters:
WIDTH, 64, data width of each input and of the output
N, 4, number of data inputs; legal range 2..16
SELW, $clog2(N), select width; derived, not overridden

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
d  input  N*WIDTH  flattened inputs; input i occupies d[i*WIDTH +: WIDTH]
sel  input  SELW  binary select, sampled with in_valid
in_valid  input  1  upstream beat present
in_ready  output  1  block can accept a beat this cycle
out_data  output  WIDTH  selected data of the head beat
out_err  output  1  head beat was captured with sel >= N
out_valid  output  1  head beat present
out_ready  input  1  downstream accepts the head beat
count  output  2  occupancy, 0..2

Behaviour:
- Reset: rst_n low asynchronously clears main_valid, skid_valid, out_data, out_err and count to 0. in_ready is 1 while rst_n is low and after release. No transfer is recorded while rst_n is low.
- Reset mid-operation: all buffered beats are discarded and none reappear after release.
- Accept: acc = in_valid & in_ready. Pop: pop = out_valid & out_ready.
- Capture: on acc, the captured data is d[sel*WIDTH +: WIDTH] from the same cycle.
  - If sel >= N (only possible when N is not a power of 2), data is all-zero and the err bit is 1.
  - Otherwise the err bit is 0.
- Storage: main register (drives out_data, out_err, out_valid) plus one skid register.
  - in_ready = ~skid_valid, taken directly from a flop with no combinational path from out_ready.
- Latency: a beat accepted in cycle t appears on out_valid/out_data in cycle t+1 at the earliest.
- Empty-to-zero-latency path: there is none; in_valid never appears combinationally on out_valid.
- Transitions, by state (main_valid, skid_valid), on each edge:
  - EMPTY (0,0):
    - acc -> ONE; the beat goes to main.
  - ONE (1,0):
    - acc & pop -> ONE; the new beat goes to main.
    - acc & ~pop -> FULL; the new beat goes to skid.
    - ~acc & pop -> EMPTY.
    - idle -> hold.
  - FULL (1,1), in_ready = 0, so acc is impossible:
    - pop -> ONE; skid moves to main.
    - otherwise hold.
- Order: beats leave in acceptance order. No beat is dropped or duplicated.
- Stability: while out_valid = 1 and out_ready = 0, out_data and out_err hold stable.
- count: equals main_valid + skid_valid and is registered.
- out_data and out_err hold their last value when out_valid = 0. They are not cleared on pop; consumers must qualify with out_valid.
- sel and d are don't-care when in_valid = 0.
- Width: no truncation or extension is performed; out_data is exactly WIDTH bits.

Test Plan:
- Reset and idle: hold rst_n low 3 cycles, release -> out_valid=0, count=0, in_ready=1, out_data=0. Then assert rst_n low asynchronously mid-cycle while count=2 -> count=0 and out_valid=0 immediately, without waiting for clk.
- Single beat: N=4, d = {3:64'hDDDD, 2:64'hCCCC, 1:64'hBBBB, 0:64'hAAAA}, sel=2, in_valid for 1 cycle, out_ready=1 -> next cycle out_valid=1, out_data=64'hCCCC, out_err=0; following cycle out_valid=0.
- Streaming: in_valid=1 continuously with sel cycling 0,1,2,3, out_ready=1 -> one beat per cycle out of AAAA, BBBB, CCCC, DDDD in order; in_ready stays 1 and count stays 1.
- Backpressure: out_ready=0, present sel=0 then sel=3 -> count=2, in_ready=0, out_data=AAAA held stable; a third offered beat is not accepted. Raise out_ready -> AAAA, then DDDD, then the third beat in consecutive cycles.
- Out-of-range select: N=3, sel=3 with d[0]=64'h1 -> out_data=0, out_err=1. A following sel=0 beat -> out_data=64'h1, out_err=0.
- Random soak: random in_valid/out_ready at 50% density, 10k beats, compared against a FIFO scoreboard model -> zero mismatches, count never exceeds 2, and no accept occurs while in_ready=0.
